// File: rtl/pla_engine_pkg.sv
// Shared types for the programmable-logic-array engine: FSM states and the
// product-term record (sized to the widest legal vectors; unused upper bits stay zero).
package pla_engine_pkg;

    localparam int PLA_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PLA_MAX_W-1:0] care;
        logic [PLA_MAX_W-1:0] pol;
        logic [PLA_MAX_W-1:0] or_row;
        logic                 en;
    } term_t;

endpackage

// File: rtl/pla_term_match.sv
// Single product-term match: enabled and every cared-for input equals its polarity.
// Latency: combinational, no registers.
// Backpressure: none; pure function of its inputs.
module pla_term_match #(
    parameter int W = 35
) (
    input  logic [W-1:0] care,
    input  logic [W-1:0] pol,
    input  logic         en,
    input  logic [W-1:0] vec,
    output logic         hit
);

    assign hit = en & ~|(care & (vec ^ pol));

endmodule

// File: rtl/pla_engine.sv
// Time-multiplexed PLA: evaluates TPC product terms per cycle over N_TERMS/TPC batches.
// Latency: result valid N_TERMS/TPC cycles after the input handshake.
// Backpressure: result held in DONE until out_ready; no new input or config accepted meanwhile.
module pla_engine
    import pla_engine_pkg::*;
#(
    parameter int N_IN    = 35,
    parameter int N_OUT   = 29,
    parameter int N_TERMS = 64,
    parameter int TPC     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
    input  logic [N_IN-1:0]            cfg_care,
    input  logic [N_IN-1:0]            cfg_pol,
    input  logic [N_OUT-1:0]           cfg_or,
    input  logic                       cfg_en,
    input  logic                       cfg_clear,
    output logic                       cfg_ready,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN-1:0]            in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_OUT-1:0]           out_vec,
    output logic                       busy
);

    localparam int NB = N_TERMS / TPC;
    localparam int AW = $clog2(N_TERMS);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    if ((N_TERMS % TPC) != 0) begin : g_bad_tpc
        $error("pla_engine: N_TERMS must be a multiple of TPC");
    end

    state_t            state;
    state_t            state_n;
    term_t             tbl [N_TERMS];
    logic [N_IN-1:0]   vec_q;
    logic [BW-1:0]     batch;
    logic [N_OUT-1:0]  acc;
    logic [N_OUT-1:0]  batch_or;
    logic [TPC-1:0]    hit;
    logic [TPC-1:0]    sel_en;
    logic [N_IN-1:0]   sel_care [TPC];
    logic [N_IN-1:0]   sel_pol  [TPC];
    logic [N_OUT-1:0]  sel_or   [TPC];
    logic              idle;
    logic              last_batch;

    function automatic logic [AW-1:0] term_idx(input logic [BW-1:0] b, input int k);
        return AW'(int'(b) * TPC + k);
    endfunction

    assign idle       = (state == ST_IDLE);
    assign last_batch = (batch == BW'(NB - 1));
    assign cfg_ready  = idle;
    assign in_ready   = idle;
    assign out_valid  = (state == ST_DONE);
    assign busy       = ~idle;
    assign out_vec    = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (in_valid)   state_n = ST_EVAL;
            ST_EVAL: if (last_batch) state_n = ST_DONE;
            ST_DONE: if (out_ready)  state_n = ST_IDLE;
            default:                 state_n = ST_IDLE;
        endcase
    end

    // Clear is issued before the write so a coinciding write leaves its term per cfg_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N_TERMS; t++) begin
                tbl[t] <= '0;
            end
        end else if (idle) begin
            if (cfg_clear) begin
                for (int t = 0; t < N_TERMS; t++) begin
                    tbl[t].en <= 1'b0;
                end
            end
            if (cfg_we) begin
                tbl[cfg_addr] <= '{care:   PLA_MAX_W'(cfg_care),
                                   pol:    PLA_MAX_W'(cfg_pol),
                                   or_row: PLA_MAX_W'(cfg_or),
                                   en:     cfg_en};
            end
        end
    end

    always_comb begin
        sel_en = '0;
        for (int k = 0; k < TPC; k++) begin
            sel_care[k] = tbl[term_idx(batch, k)].care[N_IN-1:0];
            sel_pol[k]  = tbl[term_idx(batch, k)].pol[N_IN-1:0];
            sel_or[k]   = tbl[term_idx(batch, k)].or_row[N_OUT-1:0];
            sel_en[k]   = tbl[term_idx(batch, k)].en;
        end
    end

    for (genvar k = 0; k < TPC; k++) begin : g_match
        pla_term_match #(
            .W (N_IN)
        ) u_match (
            .care (sel_care[k]),
            .pol  (sel_pol[k]),
            .en   (sel_en[k]),
            .vec  (vec_q),
            .hit  (hit[k])
        );
    end

    always_comb begin
        batch_or = '0;
        for (int k = 0; k < TPC; k++) begin
            if (hit[k]) batch_or = batch_or | sel_or[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
            batch <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        vec_q <= in_vec;
                        acc   <= '0;
                        batch <= '0;
                    end
                end
                ST_EVAL: begin
                    acc   <= acc | batch_or;
                    batch <= last_batch ? '0 : batch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_engine.sv
module tb_pla_engine;

    localparam int N_IN    = 35;
    localparam int N_OUT   = 29;
    localparam int N_TERMS = 64;
    localparam int TPC     = 8;
    localparam int AW      = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [N_IN-1:0]   cfg_care = '0;
    logic [N_IN-1:0]   cfg_pol = '0;
    logic [N_OUT-1:0]  cfg_or = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_clear = 1'b0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_IN-1:0]   in_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N_OUT-1:0]  out_vec;
    logic              busy;

    int errors = 0;
    int checks = 0;

    pla_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .TPC(TPC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
        .cfg_or(cfg_or), .cfg_en(cfg_en), .cfg_clear(cfg_clear), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_term(input logic [AW-1:0] a, input logic [N_IN-1:0] care,
                              input logic [N_IN-1:0] pol, input logic [N_OUT-1:0] orr,
                              input logic en);
        cfg_we = 1'b1; cfg_addr = a; cfg_care = care; cfg_pol = pol; cfg_or = orr; cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    // Launch one evaluation, scramble in_vec after the handshake, wait for the result.
    task automatic run_eval(input logic [N_IN-1:0] v, output logic [N_OUT-1:0] res,
                            output int lat);
        in_vec = v; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_vec = ~v; lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        res = out_vec;
        step();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [N_OUT-1:0] r;
        int lat;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        checks++; if (out_vec !== '0) begin errors++; $display("FAIL rst_out_vec: got %h want 0", out_vec); end
        run_eval(35'h7_FFFF_FFFF, r, lat);
        checks++; if (r !== '0) begin errors++; $display("FAIL rst_empty_eval: got %h want 0", r); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL rst_latency: got %0d want 8", lat); end
    endtask

    task automatic test_basic();
        logic [N_OUT-1:0] r;
        int lat;
        write_term(6'd0, 35'h8_0007, '1, 29'h40, 1'b1);
        run_eval(35'h8_0007, r, lat);
        checks++; if (r !== 29'h40) begin errors++; $display("FAIL basic_match: got %h want 40", r); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        run_eval(35'h0_0007, r, lat);
        checks++; if (r !== '0) begin errors++; $display("FAIL basic_bit19_clear: got %h want 0", r); end
        run_eval(35'h7_FFFF_FFFF, r, lat);
        checks++; if (r !== 29'h40) begin errors++; $display("FAIL basic_dont_care: got %h want 40", r); end
    endtask

    task automatic test_first_last();
        logic [N_OUT-1:0] r;
        int lat;
        write_term(6'd3,  35'h20, 35'h20, 29'h1, 1'b1);
        write_term(6'd60, 35'h4_0000_0000, 35'h4_0000_0000, 29'h1000_0000, 1'b1);
        write_term(6'd1,  35'h8, 35'h0, 29'h2, 1'b1);
        run_eval(35'h4_0000_0028, r, lat);
        checks++; if (r !== 29'h1000_0001) begin errors++; $display("FAIL first_last: got %h want 10000001", r); end
        run_eval(35'h4_0000_0020, r, lat);
        checks++; if (r !== 29'h1000_0003) begin errors++; $display("FAIL complement_lit: got %h want 10000003", r); end
        run_eval(35'h4_0000_0008, r, lat);
        checks++; if (r !== 29'h1000_0000) begin errors++; $display("FAIL last_only: got %h want 10000000", r); end
        run_eval(35'h0_0000_0028, r, lat);
        checks++; if (r !== 29'h1) begin errors++; $display("FAIL first_only: got %h want 1", r); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_vec = 35'h8_000F; in_valid = 1'b1;
        step();
        in_vec = 35'h20;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL eval_busy: got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL eval_in_ready: got %b want 0", in_ready); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL eval_cfg_ready: got %b want 0", cfg_ready); end
        wait_done(lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", lat); end
        repeat (20) begin
            checks++; if (out_vec !== 29'h40) begin errors++; $display("FAIL bp_hold_vec: got %h want 40", out_vec); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_hs: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_cfg_during_eval();
        logic [N_OUT-1:0] r;
        int lat;
        in_vec = 35'h8_0007; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        write_term(6'd0, 35'h0, 35'h0, 29'h0, 1'b0);
        wait_done(lat);
        checks++; if (out_vec !== 29'h42) begin errors++; $display("FAIL cfg_ignored_cur: got %h want 42", out_vec); end
        step();
        run_eval(35'h8_0007, r, lat);
        checks++; if (r !== 29'h42) begin errors++; $display("FAIL cfg_ignored_next: got %h want 42", r); end
    endtask

    task automatic test_reset_mid_eval();
        logic [N_OUT-1:0] r;
        int lat;
        bit seen;
        in_vec = 35'h4_0000_0020; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== '0) begin
            errors++; $display("FAIL midrst_async: got ov=%b busy=%b vec=%h want 0/0/0", out_valid, busy, out_vec);
        end
        seen = 1'b0;
        repeat (3) begin step(); if (out_valid) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (12) begin step(); if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse: got pulse=%b want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        run_eval(35'h4_0000_0020, r, lat);
        checks++; if (r !== '0) begin errors++; $display("FAIL midrst_en_cleared: got %h want 0", r); end
        run_eval(35'h8_0007, r, lat);
        checks++; if (r !== '0) begin errors++; $display("FAIL midrst_term0_cleared: got %h want 0", r); end
    endtask

    task automatic test_same_edge();
        logic [N_OUT-1:0] r;
        int lat;
        write_term(6'd3, 35'h20, 35'h20, 29'h100, 1'b1);
        cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd5;
        cfg_care = '0; cfg_pol = '0; cfg_or = 29'hFF; cfg_en = 1'b1;
        in_vec = 35'h20; in_valid = 1'b1;
        step();
        cfg_clear = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; in_vec = '0;
        wait_done(lat);
        checks++; if (out_vec !== 29'hFF) begin errors++; $display("FAIL same_edge_vec: got %h want ff", out_vec); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL same_edge_latency: got %0d want 8", lat); end
        step();
        run_eval(35'h0, r, lat);
        checks++; if (r !== 29'hFF) begin errors++; $display("FAIL same_edge_zero_vec: got %h want ff", r); end
        run_eval(35'h7_FFFF_FFFF, r, lat);
        checks++; if (r !== 29'hFF) begin errors++; $display("FAIL same_edge_ones_vec: got %h want ff", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_first_last();
        test_backpressure();
        test_cfg_during_eval();
        test_reset_mid_eval();
        test_same_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pla_engine.md
PLA_ENGINE -- requirements
Module: pla_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 35, giving the input vector width (legal range 1..64).
REQ-002 The block SHALL have parameter N_OUT, default 29, giving the output vector width (legal range 1..64).
REQ-003 The block SHALL have parameter N_TERMS, default 64, giving the product-term table depth.
REQ-004 The block SHALL have parameter TPC, default 8, giving terms evaluated per cycle; N_TERMS SHALL be a multiple of TPC (elaboration error otherwise); NB = N_TERMS/TPC.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cfg_we  in  1  table write strobe.
REQ-008 cfg_addr  in  clog2(N_TERMS)  term index.
REQ-009 cfg_care  in  N_IN  per-input care mask (1 = literal present).
REQ-010 cfg_pol  in  N_IN  literal polarity (1 = true, 0 = complemented).
REQ-011 cfg_or  in  N_OUT  OR-plane row (outputs driven by this term).
REQ-012 cfg_en  in  1  term enable written with the row.
REQ-013 cfg_clear  in  1  clear all term enables.
REQ-014 cfg_ready  out  1  high only in IDLE; config accepted only when high.
REQ-015 in_valid / in_ready / in_vec[N_IN]  in/out/in  evaluation request, valid-ready handshake.
REQ-016 out_valid / out_ready / out_vec[N_OUT]  out/in/out  result, valid-ready handshake.
REQ-017 busy  out  1  high in EVAL or DONE.

Function
REQ-018 Term t SHALL match iff en[t]=1 and, for every i with care[t][i]=1, in_vec[i]==pol[t][i]; an enabled term with all-zero care SHALL always match.
REQ-019 out_vec SHALL equal the bitwise OR of or[t] over all matching terms; zero if none match.
REQ-020 FSM states SHALL be IDLE, EVAL, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-021 IDLE->EVAL on in_valid&in_ready: in_vec captured, accumulator cleared, batch counter = 0.
REQ-022 In EVAL, each cycle SHALL evaluate terms [b*TPC, b*TPC+TPC-1] and OR results into the accumulator; after batch NB-1 go to DONE.
REQ-023 out_valid SHALL assert exactly NB cycles after the input handshake edge (8 for defaults).
REQ-024 DONE SHALL hold out_vec stable until out_valid&out_ready, then return to IDLE; no cycle both in_ready and out_valid.
REQ-025 cfg_we with cfg_ready writes care/pol/or/en at cfg_addr on that edge; cfg_we when cfg_ready=0 SHALL be ignored with no state change.
REQ-026 cfg_clear with cfg_ready zeroes all en bits in one edge; if cfg_we coincides, clear applies first, then the write (addressed term ends enabled per cfg_en).
REQ-027 cfg_we and in_valid accepted on the same IDLE edge: evaluation SHALL use the updated table.
REQ-028 in_vec changes after the handshake SHALL NOT affect the result.

Reset
REQ-029 On rst_n low: state=IDLE, all en=0, out_vec=0, out_valid=0, in_ready=1 (after release), cfg_ready=1, busy=0, batch counter=0; care/pol/or contents need not reset.
REQ-030 Reset mid-EVAL or mid-DONE SHALL abandon the operation with no out_valid pulse.

Structure
REQ-031 Package pla_engine_pkg SHALL hold the state enum and a parametrisable term-record type (care, pol, or, en).
REQ-032 Sub-module pla_term_match SHALL implement the combinational single-term match (REQ-018); TPC instances in the top.

Verification
REQ-033 Program term 0 care={0,1,2,19}, pol all 1, or=bit6, en=1; in_vec with bits 0,1,2,19 set -> out_vec=0x0000040 after 8 cycles; clear bit 19 -> out_vec=0.
REQ-034 Terms 3 and 60 both matching with or=0x1 and 0x10000000 -> out_vec=0x10000001 (confirms first and last batch).
REQ-035 Hold out_ready=0 for 20 cycles in DONE -> out_vec stable, in_ready=0, new in_valid not accepted.
REQ-036 cfg_we during EVAL writing term 0 en=0 -> ignored; current and next results still include term 0.
REQ-037 Assert rst_n=0 in EVAL batch 4 -> no out_valid, all en=0; post-reset eval of any vector -> out_vec=0.
REQ-038 Same-edge cfg_clear+cfg_we(term 5, care=0, or=0xFF, en=1)+in_valid -> out_vec=0xFF for any in_vec.
